// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - funct codes and sequencer state encoding shared across the ALU slice
package alu_pkg;

    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Ops the external ALU completes in a single pass.
    function automatic logic is_alu_op(input logic [5:0] fn);
        return (fn == FN_AND) || (fn == FN_OR) || (fn == FN_ADD) ||
               (fn == FN_SUB) || (fn == FN_SLT);
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - one-op-at-a-time controller for the external ALU, with MULTU shift-add and HI/LO
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [5:0]       alu_signal,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             out_valid,
    output logic [WIDTH-1:0] dataOut,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]       state;
    logic [5:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] cnt;
    logic             err_r;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign err       = err_r && (state == DONE);

    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_signal = FN_ADD;
        case (state)
            EXEC: begin
                alu_a      = a_r;
                alu_b      = b_r;
                alu_signal = op_r;
            end
            MUL: begin
                // Partial-product step: add the multiplicand when the current multiplier bit is set.
                alu_a      = hi;
                alu_b      = lo[0] ? mcand : '0;
                alu_signal = FN_ADD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            op_r    <= FN_ADD;
            a_r     <= '0;
            b_r     <= '0;
            mcand   <= '0;
            cnt     <= '0;
            err_r   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            dataOut <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r  <= Signal;
                        a_r   <= dataA;
                        b_r   <= dataB;
                        err_r <= 1'b0;
                        if (is_alu_op(Signal)) begin
                            state <= EXEC;
                        end else if (Signal == FN_MULTU) begin
                            mcand <= dataA;
                            lo    <= dataB;
                            hi    <= '0;
                            cnt   <= '0;
                            state <= MUL;
                        end else if (Signal == FN_MFHI) begin
                            dataOut <= hi;
                            state   <= DONE;
                        end else if (Signal == FN_MFLO) begin
                            dataOut <= lo;
                            state   <= DONE;
                        end else begin
                            dataOut <= '0;
                            err_r   <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                EXEC: begin
                    dataOut <= alu_result;
                    state   <= DONE;
                end
                MUL: begin
                    hi <= {alu_cout, alu_result[WIDTH-1:1]};
                    lo <= {alu_result[0], lo[WIDTH-1:1]};
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        dataOut <= {alu_result[0], lo[WIDTH-1:1]};
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed vector bench for alu_sequencer with a behavioural external ALU
module tb_alu_sequencer;

    localparam logic [5:0] S_AND   = 6'b100100;
    localparam logic [5:0] S_OR    = 6'b100101;
    localparam logic [5:0] S_ADD   = 6'b100000;
    localparam logic [5:0] S_SUB   = 6'b100010;
    localparam logic [5:0] S_SLT   = 6'b101010;
    localparam logic [5:0] S_MULTU = 6'b011001;
    localparam logic [5:0] S_MFHI  = 6'b010000;
    localparam logic [5:0] S_MFLO  = 6'b010010;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  Signal;
    logic [31:0] dataA, dataB;
    logic [31:0] alu_a, alu_b;
    logic [5:0]  alu_signal;
    logic [31:0] alu_result;
    logic        alu_cout;
    logic        out_valid;
    logic [31:0] dataOut;
    logic        err;
    logic [31:0] hi, lo;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Signal(Signal), .dataA(dataA), .dataB(dataB),
        .alu_a(alu_a), .alu_b(alu_b), .alu_signal(alu_signal),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .out_valid(out_valid), .dataOut(dataOut), .err(err), .hi(hi), .lo(lo)
    );

    // Stand-in for the external ALU.
    logic [32:0] sum33;
    always_comb begin
        sum33      = 33'd0;
        alu_result = 32'd0;
        alu_cout   = 1'b0;
        case (alu_signal)
            S_AND: alu_result = alu_a & alu_b;
            S_OR:  alu_result = alu_a | alu_b;
            S_ADD: begin
                sum33      = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = sum33[31:0];
                alu_cout   = sum33[32];
            end
            S_SUB: begin
                sum33      = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_result = sum33[31:0];
                alu_cout   = sum33[32];
            end
            S_SLT: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0]  sig;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic run_vec(input vec_t v, input int idx);
        int got = 0;
        logic ready_bad = 1'b0;
        logic sig_bad = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d in_ready before accept", idx), {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        Signal   = v.sig;
        dataA    = v.a;
        dataB    = v.b;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            if (k == 1 && v.lat == 2 &&
                (alu_signal !== v.sig || alu_a !== v.a || alu_b !== v.b)) sig_bad = 1'b1;
            if (out_valid) begin
                got = k;
                break;
            end
            if (in_ready) ready_bad = 1'b1;
        end
        check($sformatf("v%0d latency", idx), got, v.lat);
        check($sformatf("v%0d dataOut", idx), dataOut, v.exp_data);
        check($sformatf("v%0d err", idx), {31'd0, err}, {31'd0, v.exp_err});
        check($sformatf("v%0d hi", idx), hi, v.exp_hi);
        check($sformatf("v%0d lo", idx), lo, v.exp_lo);
        check($sformatf("v%0d in_ready busy", idx), {31'd0, ready_bad}, 32'd0);
        if (v.lat == 2) check($sformatf("v%0d alu drive in EXEC", idx), {31'd0, sig_bad}, 32'd0);
        @(negedge clk);
        check($sformatf("v%0d out_valid one pulse", idx), {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int got;
        int pulses;
        logic ready_bad;
        reset    = 1'b0;
        in_valid = 1'b0;
        Signal   = 6'd0;
        dataA    = 32'd0;
        dataB    = 32'd0;

        //               sig      a             b             data          err   hi            lo            lat
        vecs.push_back('{S_ADD,   32'd5,        32'd7,        32'h0000000C, 1'b0, 32'h0,        32'h0,        2});
        vecs.push_back('{S_SUB,   32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 32'h0,        32'h0,        2});
        vecs.push_back('{S_SLT,   32'd3,        32'd5,        32'h00000001, 1'b0, 32'h0,        32'h0,        2});
        vecs.push_back('{S_AND,   32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 1'b0, 32'h0,        32'h0,        2});
        vecs.push_back('{S_OR,    32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 32'h0,        32'h0,        2});
        vecs.push_back('{S_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 32'h0,        32'h0,        2});
        vecs.push_back('{S_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 32'h0,        32'h0,        2});
        vecs.push_back('{S_SLT,   32'd5,        32'd3,        32'h00000000, 1'b0, 32'h0,        32'h0,        2});
        vecs.push_back('{S_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'hFFFFFFFE, 32'h00000001, 33});
        vecs.push_back('{S_MFHI,  32'h0,        32'h0,        32'hFFFFFFFE, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1});
        vecs.push_back('{S_MFLO,  32'h0,        32'h0,        32'h00000001, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1});
        vecs.push_back('{S_ADD,   32'd1,        32'd2,        32'h00000003, 1'b0, 32'hFFFFFFFE, 32'h00000001, 2});
        vecs.push_back('{S_MULTU, 32'h00010000, 32'h00010003, 32'h00030000, 1'b0, 32'h00000001, 32'h00030000, 33});
        vecs.push_back('{6'b111111, 32'h1,      32'h2,        32'h00000000, 1'b1, 32'h00000001, 32'h00030000, 1});
        vecs.push_back('{S_MFHI,  32'h0,        32'h0,        32'h00000001, 1'b0, 32'h00000001, 32'h00030000, 1});
        vecs.push_back('{6'b000000, 32'h0,      32'h0,        32'h00000000, 1'b1, 32'h00000001, 32'h00030000, 1});
        vecs.push_back('{S_MULTU, 32'd7,        32'd6,        32'h0000002A, 1'b0, 32'h00000000, 32'h0000002A, 33});

        // Reset state while held in reset.
        repeat (2) @(negedge clk);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        check("reset dataOut", dataOut, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset alu_a", alu_a, 32'd0);
        check("reset alu_b", alu_b, 32'd0);
        check("reset alu_signal", {26'd0, alu_signal}, {26'd0, S_ADD});
        reset = 1'b1;
        @(negedge clk);
        check("in_ready after release", {31'd0, in_ready}, 32'd1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // MULTU by zero with in_valid held high: next op only accepted once back in IDLE.
        @(negedge clk);
        in_valid = 1'b1;
        Signal   = S_MULTU;
        dataA    = 32'h12345678;
        dataB    = 32'h0;
        @(posedge clk);
        @(negedge clk);
        Signal = S_ADD;
        dataA  = 32'd5;
        dataB  = 32'd7;
        got = 0;
        pulses = 0;
        ready_bad = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (out_valid) begin
                pulses++;
                if (got == 0) begin
                    got = k;
                    check("held multu dataOut", dataOut, 32'd0);
                    check("held multu hi", hi, 32'd0);
                    check("held multu lo", lo, 32'd0);
                end
            end
            if (k < 33 && in_ready) ready_bad = 1'b1;
            if (k == 34) begin
                check("held in_ready back in IDLE", {31'd0, in_ready}, 32'd1);
                @(posedge clk);
                @(negedge clk);
                in_valid = 1'b0;
                break;
            end
        end
        check("held multu latency", got, 33);
        check("held multu no early accept", {31'd0, ready_bad}, 32'd0);
        check("held multu single pulse", pulses, 1);
        got = 0;
        for (int k = 1; k <= 5; k++) begin
            if (out_valid) begin
                got = k + 34;
                break;
            end
            @(negedge clk);
        end
        check("held add latency", got, 36);
        check("held add dataOut", dataOut, 32'h0000000C);

        // Reset asserted during MUL iteration 10.
        @(negedge clk);
        in_valid = 1'b1;
        Signal   = S_MULTU;
        dataA    = 32'hFFFFFFFF;
        dataB    = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset hi", hi, 32'd0);
        check("midreset lo", lo, 32'd0);
        check("midreset dataOut", dataOut, 32'd0);
        check("midreset alu_a", alu_a, 32'd0);
        check("midreset alu_signal", {26'd0, alu_signal}, {26'd0, S_ADD});
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) pulses++;
            if (k == 2) reset = 1'b1;
        end
        check("midreset no out_valid", pulses, 0);
        run_vec('{S_ADD, 32'd5, 32'd7, 32'h0000000C, 1'b0, 32'h0, 32'h0, 2}, 99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
